// File: rtl/alu_two_port_arbiter.sv
// Round-robin front end that shares one 8-bit ALU between two valid/ready requesters.
// Each requester keeps its own carry flag so interleaved multi-byte chains stay independent.
//
// state | meaning
// IDLE  | arbitrate; the granted requester sees ready, and the handshake captures the op
// EXEC  | ALU driven from the op registers; result, carry and flag captured at the edge
// RESP  | response held on resp_* until resp_ready
module alu_two_port_arbiter #(
    parameter int DATA_W         = 8,
    parameter int SEL_W          = 4,
    parameter int FLAG_LOGIC_OPS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req0_use_carry,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic              req1_use_carry,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel_code,
    output logic              alu_c_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_c_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SEL_W-1:0]  op_sel;
    logic              op_use_carry;
    logic              op_id;
    logic              last_grant;
    logic [1:0]        flag;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              flag_wr;

    // On a tie the requester that did not win last time is served.
    assign grant0  = req0_valid & (~req1_valid | last_grant);
    assign grant1  = req1_valid & (~req0_valid | ~last_grant);
    assign accept  = (state == IDLE) & (req0_valid | req1_valid);
    assign flag_wr = ~op_sel[SEL_W-1] | (FLAG_LOGIC_OPS != 0);

    assign req0_ready   = (state == IDLE) & grant0;
    assign req1_ready   = (state == IDLE) & grant1;
    assign resp_valid   = (state == RESP);
    assign busy         = (state != IDLE);

    assign alu_a        = op_a;
    assign alu_b        = op_b;
    assign alu_sel_code = op_sel;
    assign alu_c_in     = op_use_carry & flag[op_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= '0;
            op_use_carry <= 1'b0;
            op_id        <= 1'b0;
            last_grant   <= 1'b1;
            flag         <= 2'b00;
            resp_result  <= '0;
            resp_c_out   <= 1'b0;
            resp_id      <= 1'b0;
        end else begin
            if (accept) begin
                op_a         <= grant1 ? req1_a : req0_a;
                op_b         <= grant1 ? req1_b : req0_b;
                op_sel       <= grant1 ? req1_sel : req0_sel;
                op_use_carry <= grant1 ? req1_use_carry : req0_use_carry;
                op_id        <= grant1;
                last_grant   <= grant1;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_c_out  <= alu_c_out;
                resp_id     <= op_id;
                if (flag_wr) begin
                    flag[op_id] <= alu_c_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_two_port_arbiter.sv
// Bench for alu_two_port_arbiter: behavioural ALU stand-in plus a transaction-level
// reference (round-robin rule, per-requester carry flags) driving directed and random ops.
module tb_alu_two_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] v;
    logic       req0_ready, req1_ready;
    logic [7:0] p_a [2];
    logic [7:0] p_b [2];
    logic [3:0] p_sel [2];
    logic       p_uc [2];
    logic [1:0] pend;
    logic [7:0] alu_a, alu_b, alu_result, resp_result;
    logic [3:0] alu_sel_code;
    logic       alu_c_in, alu_c_out;
    logic       resp_valid, resp_ready, resp_id, resp_c_out, busy;

    logic [1:0] mflag;
    logic       mlast;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    alu_two_port_arbiter #(.DATA_W(8), .SEL_W(4), .FLAG_LOGIC_OPS(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(p_a[0]), .req0_b(p_b[0]),
        .req0_sel(p_sel[0]), .req0_use_carry(p_uc[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(p_a[1]), .req1_b(p_b[1]),
        .req1_sel(p_sel[1]), .req1_use_carry(p_uc[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel_code(alu_sel_code), .alu_c_in(alu_c_in),
        .alu_result(alu_result), .alu_c_out(alu_c_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_c_out(resp_c_out), .busy(busy)
    );

    // Stand-in ALU: arithmetic codes return {carry/borrow, result}; logic codes report a[7] as carry.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel, input logic cin);
        logic [8:0] r;
        case (sel)
            4'b0000: r = {1'b0, a} + {8'd0, cin};
            4'b0001, 4'b0010: r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'b0011: r = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            4'b0100: r = {1'b0, b} - {1'b0, a} - {8'd0, cin};
            4'b1000: r = {a[7], a & b};
            4'b1001: r = {a[7], a | b};
            4'b1010: r = {a[7], a ^ b};
            4'b1011: r = {a[7], ~a};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign {alu_c_out, alu_result} = alu_fn(alu_a, alu_b, alu_sel_code, alu_c_in);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic uc);
        p_a[id] = a; p_b[id] = b; p_sel[id] = sel; p_uc[id] = uc; pend[id] = 1'b1;
    endtask

    task automatic model_reset();
        mflag = 2'b00;
        mlast = 1'b1;
    endtask

    // Called at a negedge with the DUT in IDLE; completes exactly one transaction.
    task automatic issue(input int hold);
        int         g;
        logic       cin;
        logic [8:0] r;
        v = pend;
        #1;
        g = (pend[0] && pend[1]) ? int'(!mlast) : (pend[1] ? 1 : 0);
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("busy_idle", busy, 0);
        cin = p_uc[g] ? mflag[g] : 1'b0;
        r = alu_fn(p_a[g], p_b[g], p_sel[g], cin);
        if (!p_sel[g][3]) mflag[g] = r[8];
        mlast = g[0];
        @(negedge clk);
        chk("exec_ready", {req0_ready, req1_ready}, 0);
        chk("exec_busy", busy, 1);
        chk("exec_rvalid", resp_valid, 0);
        chk("alu_a", alu_a, p_a[g]);
        chk("alu_b", alu_b, p_b[g]);
        chk("alu_sel", alu_sel_code, p_sel[g]);
        chk("alu_cin", alu_c_in, cin);
        pend[g] = 1'b0;
        v[g] = 1'b0;
        @(negedge clk);
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, g);
        chk("resp_result", resp_result, r[7:0]);
        chk("resp_c_out", resp_c_out, r[8]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_result", {resp_id, resp_c_out, resp_result}, {g[0], r});
            chk("hold_ready", {req0_ready, req1_ready}, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("back_idle", {resp_valid, busy}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v = 2'b00;
        pend = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] sels [9];
        sels = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_a[i] = '0; p_b[i] = '0; p_sel[i] = '0; p_uc[i] = 1'b0;
        end
        @(negedge clk);
        do_reset();

        chk("rst_state", {resp_valid, busy, req0_ready, req1_ready}, 0);
        chk("rst_resp", {resp_id, resp_c_out, resp_result}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel_code, alu_c_in}, 0);

        // T1 / T2: simple add, carry out, then carry chained into the next op
        set_op(0, 8'h0F, 8'h01, 4'b0001, 1'b0); issue(0);
        set_op(0, 8'hFF, 8'h01, 4'b0001, 1'b0); issue(0);
        set_op(0, 8'h00, 8'h00, 4'b0010, 1'b1); issue(0);

        // T3: both requesters continuously valid alternate strictly from reset
        do_reset();
        set_op(0, 8'h11, 8'h22, 4'b0001, 1'b0);
        set_op(1, 8'h33, 8'h44, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(0);
            set_op(int'(mlast), 8'(i * 7), 8'(i + 3), 4'b0001, 1'b0);
        end
        pend = 2'b00;
        v = 2'b00;

        // T4: borrow on subtract, response held for 5 cycles
        set_op(1, 8'h00, 8'h01, 4'b0011, 1'b0); issue(5);

        // T5: flag[0] independent of flag[1]; logic op leaves flag[1] set
        set_op(0, 8'h01, 8'h01, 4'b0001, 1'b1); issue(0);
        set_op(1, 8'h0F, 8'h3C, 4'b1000, 1'b0); issue(0);
        set_op(1, 8'h00, 8'h00, 4'b0010, 1'b1); issue(0);

        // T6: reset while an op is in EXEC discards it and clears flags
        set_op(1, 8'h00, 8'h01, 4'b0011, 1'b0); issue(0);
        set_op(0, 8'h55, 8'h11, 4'b0001, 1'b0);
        v = pend;
        @(negedge clk);
        chk("t6_in_exec", busy, 1);
        rst = 1'b1;
        pend = 2'b00;
        v = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("t6_rst_state", {resp_valid, busy}, 0);
        chk("t6_rst_alu", {alu_a, alu_b, alu_sel_code}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_resp", {resp_valid, resp_result, resp_c_out}, 0);
        end
        set_op(1, 8'h00, 8'h00, 4'b0001, 1'b1); issue(0);

        // Random interleaving of both requesters
        for (int n = 0; n < 200; n++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pend[id] && $urandom_range(0, 2) != 0)
                    set_op(id, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                           sels[$urandom_range(0, 8)], 1'($urandom));
            end
            if (pend == 2'b00)
                set_op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                       sels[$urandom_range(0, 8)], 1'($urandom));
            issue(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
